// File: rtl/fifo_ctrl.sv
// Pointer/flag controller driving a REG_FILE to form a synchronous show-ahead FIFO.
// Optional sticky overflow/underflow error flags are built only when FIFO_CTRL_ERR_EN is defined.
module fifo_ctrl #(
    parameter int unsigned ADDR_WIDTH = 3,
    parameter int unsigned AF_LEVEL   = 6,
    parameter int unsigned AE_LEVEL   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr,
    input  logic                  rd,
    output logic                  w_en,
    output logic [ADDR_WIDTH-1:0] w_addr,
    output logic [ADDR_WIDTH-1:0] r_addr,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
    localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [ADDR_WIDTH:0]   cnt;
    logic                  push_ok;
    logic                  pop_ok;

    // Reset dominates: no REG_FILE write is issued while rst_n is low.
    assign push_ok = rst_n & wr & (~full | rd);
    assign pop_ok  = rd & ~empty;
    assign w_en    = push_ok;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign w_addr       = wr_ptr;
    assign r_addr       = rd_ptr;
    assign count        = cnt;
    assign full         = (cnt == DEPTH_C);
    assign empty        = (cnt == '0);
    assign almost_full  = (cnt >= AF_C);
    assign almost_empty = (cnt <= AE_C);

`ifdef FIFO_CTRL_ERR_EN
    logic ovf_q;
    logic unf_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (wr & full & ~rd)
                ovf_q <= 1'b1;
            if (rd & empty)
                unf_q <= 1'b1;
        end
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_ctrl.sv
// Self-checking bench for fifo_ctrl with a behavioural REG_FILE (async read) attached.
// Table-driven fill/drain vectors plus hand sequences for wrap, simultaneous ops and reset.
module tb_fifo_ctrl;

    localparam int unsigned AW    = 3;
    localparam int          DEPTH = 8;
    localparam int          AF    = 6;
    localparam int          AE    = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr = 1'b1;
    logic          rd = 1'b1;
    logic          w_en;
    logic [AW-1:0] w_addr;
    logic [AW-1:0] r_addr;
    logic          full, empty, almost_full, almost_empty;
    logic [AW:0]   count;
    logic          overflow, underflow;
    logic [7:0]    w_data = '0;
    logic [7:0]    r_data;
    logic [7:0]    mem [DEPTH];

    fifo_ctrl #(.ADDR_WIDTH(AW), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
        .clk(clk), .rst_n(rst_n), .wr(wr), .rd(rd),
        .w_en(w_en), .w_addr(w_addr), .r_addr(r_addr),
        .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (w_en) mem[w_addr] <= w_data;
    assign r_data = mem[r_addr];

    int passed = 0;
    int total  = 0;

    int         m_cnt = 0, m_wp = 0, m_rp = 0;
    bit         m_ovf = 0, m_unf = 0;
    logic [7:0] sb[$];

    typedef struct {
        logic wr;
        logic rd;
        logic wen;
        int   cnt;
    } vec_t;
    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    task automatic check_state();
        chk("count", count, m_cnt);
        chk("full", full, m_cnt == DEPTH);
        chk("empty", empty, m_cnt == 0);
        chk("almost_full", almost_full, m_cnt >= AF);
        chk("almost_empty", almost_empty, m_cnt <= AE);
        chk("w_addr", w_addr, m_wp);
        chk("r_addr", r_addr, m_rp);
        chk("overflow", overflow, m_ovf);
        chk("underflow", underflow, m_unf);
    endtask

    // Called at posedge+1; returns w_en as sampled at the preceding negedge.
    task automatic step(input logic w, input logic r, input logic [7:0] d, output logic got_wen);
        bit         push, pop;
        logic [7:0] exp;
        wr = w; rd = r; w_data = d;
        push = w && (m_cnt != DEPTH || r);
        pop  = r && (m_cnt != 0);
        @(negedge clk);
        got_wen = w_en;
        chk("w_en", w_en, push);
        if (pop) begin
            if (sb.size() == 0) chk("sb_underrun", 0, 1);
            else begin
                exp = sb.pop_front();
                chk("r_data", r_data, exp);
            end
        end
        if (push) sb.push_back(d);
`ifdef FIFO_CTRL_ERR_EN
        if (w && m_cnt == DEPTH && !r) m_ovf = 1;
        if (r && m_cnt == 0) m_unf = 1;
`endif
        m_cnt = m_cnt + int'(push) - int'(pop);
        m_wp  = (m_wp + int'(push)) % DEPTH;
        m_rp  = (m_rp + int'(pop)) % DEPTH;
        @(posedge clk); #1;
        check_state();
        wr = 0; rd = 0;
    endtask

    task automatic do_reset(input int n, input logic w, input logic r);
        rst_n = 0; wr = w; rd = r;
        repeat (n) begin
            @(negedge clk);
            chk("rst_w_en", w_en, 0);
            @(posedge clk); #1;
        end
        m_cnt = 0; m_wp = 0; m_rp = 0; m_ovf = 0; m_unf = 0;
        sb.delete();
        rst_n = 1; wr = 0; rd = 0;
        check_state();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       g;
        logic [7:0] d;
        int         k;

        for (int i = 1; i <= DEPTH; i++) vecs.push_back('{1'b1, 1'b0, 1'b1, i});
        vecs.push_back('{1'b1, 1'b0, 1'b0, DEPTH});
        for (int i = 1; i <= DEPTH; i++) vecs.push_back('{1'b0, 1'b1, 1'b0, DEPTH - i});
        vecs.push_back('{1'b0, 1'b1, 1'b0, 0});

        // Reset with wr/rd both high for two cycles.
        do_reset(2, 1'b1, 1'b1);

        // Fill with 0x11..0x88, one extra push, drain, one extra pop.
        k = 0;
        foreach (vecs[i]) begin
            if (vecs[i].wr) k++;
            d = (k <= DEPTH) ? 8'(8'h11 * k) : 8'h99;
            step(vecs[i].wr, vecs[i].rd, d, g);
            chk("vec_w_en", g, vecs[i].wen);
            chk("vec_count", count, vecs[i].cnt);
        end

        // Wrap: push 5, pop 5, push 6 (w_addr wraps 7->0), drain 6.
        for (int i = 0; i < 5; i++) step(1, 0, 8'($urandom), g);
        for (int i = 0; i < 5; i++) step(0, 1, 8'h00, g);
        for (int i = 0; i < 6; i++) step(1, 0, 8'(8'hA0 + i), g);
        chk("wrap_count", count, 6);
        for (int i = 0; i < 6; i++) step(0, 1, 8'h00, g);

        // Simultaneous wr&rd at empty: push only, read pointer holds.
        k = m_rp;
        step(1, 1, 8'h5A, g);
        chk("sim_empty_count", count, 1);
        chk("sim_empty_rp", r_addr, k);

        // Fill to full, then wr&rd at full: both accepted, count stays 8.
        for (int i = 0; i < DEPTH - 1; i++) step(1, 0, 8'($urandom), g);
        step(1, 1, 8'hC3, g);
        chk("sim_full_count", count, DEPTH);
        step(0, 1, 8'h00, g);

        // Down to four entries, then a one-cycle reset mid-operation.
        for (int i = 0; i < 3; i++) step(0, 1, 8'h00, g);
        chk("pre_reset_count", count, 4);
        do_reset(1, 1'b1, 1'b0);
        chk("post_reset_empty", empty, 1);

        // Operation resumes cleanly after reset.
        step(1, 0, 8'h3C, g);
        step(0, 1, 8'h00, g);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
